spram_line_fetch: RTL and testbench

Line-buffered pixel fetcher between the SPRAM frame store and the VGA output stage in display mode (state 3). It answers the VGA timing generator's end-of-line read pulse by fetching the next display line from SPRAM into a ping-pong line buffer. It also drives registered RGB565 pixel data and data-enable aligned to the generator's xpos/ypos. The block is the responder to the timing generator's read request, and the initiator of word reads on the SPRAM read port.

---
 rtl/spram_line_fetch.sv | 136 +++++++++++++
 tb/tb_spram_line_fetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_line_fetch.sv
// Line-buffered pixel fetcher: on each end-of-line pulse in display mode it
// pulls the next visible line from SPRAM into one half of a ping-pong line
// buffer, while the other half feeds registered RGB565 pixels to the VGA stage.
//
// FSM states
//   state  | meaning
//   S_IDLE | no fetch outstanding
//   S_REQ  | mem_req high, one word stored per mem_ack
//   S_DONE | last word stored, one settling cycle before S_IDLE
module spram_line_fetch #(
  parameter int H_DISP = 800,
  parameter int V_DISP = 600,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        state,
  input  logic              spram_rd_sig,
  input  logic [9:0]        xpos,
  input  logic [9:0]        ypos,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_rgb,
  output logic              pix_de,
  output logic              fetch_busy,
  output logic              overrun
);

  localparam logic [7:0] ST_DISPLAY = 8'h03;
  localparam logic [9:0] H_LIM      = 10'(H_DISP);
  localparam logic [9:0] H_LAST     = 10'(H_DISP - 1);
  localparam logic [9:0] V_LIM      = 10'(V_DISP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t fsm_q;
  fsm_t fsm_d;

  logic [DATA_W-1:0] line_buf [2][H_DISP];

  logic [9:0]        col;
  logic              wr_bank;
  logic              display_mode;
  logic [9:0]        t_line;
  logic [ADDR_W-1:0] base;
  logic              trig;
  logic              wr_en;
  logic              last_word;
  logic              pix_vis;

  assign display_mode = (state == ST_DISPLAY);
  // 10-bit wrap makes the blank line 1023 fetch line 0 for the next frame.
  assign t_line       = ypos + 10'd1;
  assign base         = ADDR_W'(t_line) * ADDR_W'(H_DISP);
  assign trig         = display_mode && spram_rd_sig && (t_line < V_LIM);
  // An ack coinciding with a restart or a mode exit is dropped.
  assign wr_en        = display_mode && !trig && (fsm_q == S_REQ) && mem_ack;
  assign last_word    = (col == H_LAST);
  assign pix_vis      = display_mode && (xpos < H_LIM) && (ypos < V_LIM);
  assign fetch_busy   = (fsm_q != S_IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= S_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next state: mode exit beats trigger, trigger beats ack
  always_comb begin
    fsm_d = fsm_q;
    if (!display_mode) begin
      fsm_d = S_IDLE;
    end else if (trig) begin
      fsm_d = S_REQ;
    end else begin
      case (fsm_q)
        S_IDLE: fsm_d = S_IDLE;
        S_REQ:  if (mem_ack && last_word) fsm_d = S_DONE;
        S_DONE: fsm_d = S_IDLE;
        default: fsm_d = S_IDLE;
      endcase
    end
  end

  // Fetch datapath: request, address, column and target bank
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      col      <= '0;
      wr_bank  <= 1'b0;
      overrun  <= 1'b0;
    end else if (!display_mode) begin
      mem_req <= 1'b0;
    end else if (trig) begin
      mem_req  <= 1'b1;
      mem_addr <= base;
      col      <= '0;
      wr_bank  <= t_line[0];
      if (fsm_q != S_IDLE) overrun <= 1'b1;
    end else if (wr_en) begin
      mem_addr <= mem_addr + ADDR_W'(1);
      col      <= col + 10'd1;
      if (last_word) mem_req <= 1'b0;
    end
  end

  // Line buffer write port; contents survive reset and mode changes
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_buf[wr_bank][col] <= mem_rdata;
    end
  end

  // Registered pixel output, one cycle behind xpos/ypos
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_de  <= 1'b0;
      pix_rgb <= '0;
    end else begin
      pix_de  <= pix_vis;
      pix_rgb <= pix_vis ? line_buf[ypos[0]][xpos] : '0;
    end
  end

endmodule

// File: tb/tb_spram_line_fetch.sv
// Bench for spram_line_fetch: directed stimulus, a transaction-level model of
// the fetch and the two line banks, and a per-cycle compare against it.
module tb_spram_line_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sys_state = 8'h01;
  logic        spram_rd_sig = 1'b0;
  logic [9:0]  xpos = 10'd900;
  logic [9:0]  ypos = 10'd900;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] pix_rgb;
  logic        pix_de;
  logic        fetch_busy;
  logic        overrun;

  logic        ack_en = 1'b1;
  logic        ack_every3 = 1'b0;
  logic [1:0]  ack_div = 2'd0;

  int n_checks = 0;
  int n_fail = 0;

  spram_line_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .state        (sys_state),
    .spram_rd_sig (spram_rd_sig),
    .xpos         (xpos),
    .ypos         (ypos),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .pix_rgb      (pix_rgb),
    .pix_de       (pix_de),
    .fetch_busy   (fetch_busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // SPRAM stand-in: data is the low 16 address bits, optional 2-cycle waits
  assign mem_rdata = mem_addr[15:0];
  assign mem_ack   = ack_en && mem_req && (ack_div == 2'd0);

  always @(posedge clk) begin
    if (ack_every3) ack_div <= (ack_div == 2'd2) ? 2'd0 : ack_div + 2'd1;
    else            ack_div <= 2'd0;
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // A fetch is a transaction: target line, words received so far, phase.
  int m_phase = 0;          // 0 none, 1 requesting words, 2 final settle cycle
  int m_line = 0;
  int m_words = 0;
  int m_addr = 0;
  bit m_req = 0;
  bit m_ovr = 0;
  bit m_de = 0;
  int m_rgb = 0;
  bit m_rgb_known = 1;
  int bufm [2][800];
  bit bufv [2][800];

  always @(posedge clk) begin
    int tl;
    bit vis;
    if (rst) begin
      m_phase = 0; m_req = 0; m_addr = 0; m_ovr = 0;
      m_de = 0; m_rgb = 0; m_rgb_known = 1;
    end else begin
      vis = (sys_state == 8'h03) && (int'(xpos) < 800) && (int'(ypos) < 600);
      m_de = vis;
      if (vis) begin
        m_rgb = bufm[ypos % 2][xpos];
        m_rgb_known = bufv[ypos % 2][xpos];
      end else begin
        m_rgb = 0;
        m_rgb_known = 1;
      end
      tl = (int'(ypos) + 1) % 1024;
      if (sys_state != 8'h03) begin
        m_phase = 0;
        m_req = 0;
      end else if (spram_rd_sig && tl < 600) begin
        if (m_phase != 0) m_ovr = 1;
        m_phase = 1; m_line = tl; m_words = 0; m_req = 1;
        m_addr = tl * 800;
      end else if (m_phase == 1 && mem_ack) begin
        bufm[m_line % 2][m_words] = int'(mem_rdata);
        bufv[m_line % 2][m_words] = 1;
        m_words++;
        m_addr = m_line * 800 + m_words;
        if (m_words == 800) begin
          m_phase = 2;
          m_req = 0;
        end
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    check("mem_req", int'(mem_req), int'(m_req));
    if (m_req) check("mem_addr", int'(mem_addr), m_addr);
    check("fetch_busy", int'(fetch_busy), int'(m_phase != 0));
    check("overrun", int'(overrun), int'(m_ovr));
    check("pix_de", int'(pix_de), int'(m_de));
    if (m_rgb_known) check("pix_rgb", int'(pix_rgb), m_rgb);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic trigger_at(input logic [9:0] y);
    ypos = y;
    spram_rd_sig = 1'b1;
    cyc();
    spram_rd_sig = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    while (fetch_busy && g < budget) begin
      cyc();
      g++;
    end
    check("idle_timeout", int'(fetch_busy), 0);
  endtask

  initial begin
    int g;
    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sys_state    = 8'($urandom_range(1, 3));
      spram_rd_sig = 1'($urandom);
      xpos         = 10'($urandom);
      ypos         = 10'($urandom);
      cyc();
      check("rst_req", int'(mem_req), 0);
      check("rst_addr", int'(mem_addr), 0);
      check("rst_pix", int'(pix_rgb) + int'(pix_de), 0);
      check("rst_busy_ovr", int'(fetch_busy) + int'(overrun), 0);
    end
    rst = 1'b0;
    sys_state = 8'h01;
    xpos = 10'd900;
    spram_rd_sig = 1'b0;
    cyc();
    trigger_at(10'd5);
    check("idle_mode_no_req", int'(mem_req), 0);
    cyc();
    check("idle_mode_no_busy", int'(fetch_busy), 0);

    // Zero-wait fetch of line 10
    sys_state = 8'h03;
    cyc();
    trigger_at(10'd9);
    check("zw_req_start", int'(mem_req), 1);
    check("zw_addr_start", int'(mem_addr), 8000);
    cyc();
    check("zw_addr_next", int'(mem_addr), 8001);
    for (int k = 2; k < 800; k++) cyc();
    check("zw_addr_last", int'(mem_addr), 8799);
    check("zw_req_last", int'(mem_req), 1);
    cyc();
    check("zw_req_fall", int'(mem_req), 0);
    check("zw_busy_done", int'(fetch_busy), 1);
    cyc();
    check("zw_busy_clear", int'(fetch_busy), 0);

    // Display alignment on line 10 (bank 0)
    ypos = 10'd10;
    for (int x = 0; x <= 800; x++) begin
      xpos = 10'(x);
      cyc();
      if (x == 0)   check("disp_x0", int'(pix_rgb), 8000);
      if (x == 0)   check("disp_de0", int'(pix_de), 1);
      if (x == 799) check("disp_x799", int'(pix_rgb), 8799);
      if (x == 800) check("disp_x800", int'(pix_rgb) + int'(pix_de), 0);
    end
    xpos = 10'd900;

    // Frame wrap
    trigger_at(10'd1023);
    check("wrap_addr0", int'(mem_addr), 0);
    check("wrap_req0", int'(mem_req), 1);
    wait_idle(1000);
    trigger_at(10'd599);
    check("no_fetch_599", int'(mem_req), 0);
    cyc();
    check("no_busy_599", int'(fetch_busy), 0);
    trigger_at(10'd598);
    check("last_line_addr", int'(mem_addr), 479200);
    wait_idle(1000);
    ypos = 10'd599;
    xpos = 10'd0;
    cyc();
    check("disp_l599_x0", int'(pix_rgb), 20448);
    xpos = 10'd5;
    cyc();
    check("disp_l599_x5", int'(pix_rgb), 20453);
    ypos = 10'd0;
    xpos = 10'd7;
    cyc();
    check("disp_l0_x7", int'(pix_rgb), 7);
    xpos = 10'd900;

    // Wait states and overrun
    ack_every3 = 1'b1;
    trigger_at(10'd20);
    check("ws_addr_start", int'(mem_addr), 16800);
    for (int k = 1; k < 1040; k++) cyc();
    check("ws_no_overrun_yet", int'(overrun), 0);
    check("ws_still_busy", int'(fetch_busy), 1);
    trigger_at(10'd20);
    check("ovr_set", int'(overrun), 1);
    check("ovr_restart_addr", int'(mem_addr), 16800);
    check("ovr_restart_req", int'(mem_req), 1);

    // Mid-fetch abort at col 400
    ack_every3 = 1'b0;
    g = 0;
    while (m_words < 400 && g < 3000) begin
      cyc();
      g++;
    end
    check("abort_reach_col400", m_words, 400);
    sys_state = 8'h02;
    cyc();
    check("abort_req", int'(mem_req), 0);
    check("abort_busy", int'(fetch_busy), 0);
    sys_state = 8'h03;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (k == 19) check("resume_no_req", int'(mem_req), 0);
    end
    check("ovr_sticky", int'(overrun), 1);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("ovr_cleared", int'(overrun), 0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
